periph_bank: RTL

Parametrised memory-mapped peripheral bank on the serial-command bus: a configurable number of writable output registers, a read-only switch port, a block RAM window, and a running CRC-8 over every byte written into the RAM. Sits behind the UART command decoder alongside other address-mapped blocks. Read data is returned on `my_dat` and OR-combined with other blocks upstream. It supersedes the fixed LED/display/256x8 bank with configurable width, depth and register count, a CRC engine, reset, and a uniform registered read path with a valid strobe.

---
 rtl/periph_bank.sv | 117 +++++++++++
 1 files changed

// File: rtl/periph_bank.sv
// Memory-mapped peripheral bank: writable output registers, switch port, RAM window
// and a running CRC-8 over bytes written into the RAM. Read data is registered.
module periph_bank #(
  parameter logic [15:0] BASE_ADR = 16'h0100,
  parameter int          N_REG    = 4,
  parameter int          DW       = 8,
  parameter int          MEM_AW   = 8,
  parameter logic [7:0]  CRC_POLY = 8'h07
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce_wr_dat,
  input  logic [DW-1:0]       rx_dat,
  input  logic [15:0]         wr_adr,
  input  logic [15:0]         rd_adr,
  input  logic [7:0]          com,
  input  logic [DW-1:0]       sw,
  output logic [N_REG*DW-1:0] reg_q,
  output logic [7:0]          crc_q,
  output logic [DW-1:0]       my_dat,
  output logic                rd_vld
);

  localparam logic [7:0]  COM_REG_WR  = 8'h00;
  localparam logic [7:0]  COM_REG_RD  = 8'h80;
  localparam logic [7:0]  COM_RAM     = 8'h81;
  localparam logic [7:0]  COM_CRC_CLR = 8'h82;
  localparam logic [15:0] WIN_SIZE    = 16'(2**MEM_AW);
  localparam logic [15:0] SW_OFF      = 16'(N_REG);
  localparam logic [15:0] CRC_OFF     = 16'(N_REG + 1);

  // MSB-first CRC-8 over one byte, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  logic [DW-1:0] mem_r [2**MEM_AW];
  logic [15:0]   wr_off_s;
  logic [15:0]   rd_off_s;
  logic          wr_above_s;
  logic          rd_above_s;
  logic          ram_wr_s;
  logic          reg_wr_s;
  logic          crc_clr_s;
  logic          rd_hit_s;
  logic [DW-1:0] rd_data_s;

  // Address decode relative to the shared base of register map and RAM window.
  always_comb begin
    wr_off_s   = wr_adr - BASE_ADR;
    rd_off_s   = rd_adr - BASE_ADR;
    wr_above_s = (wr_adr >= BASE_ADR);
    rd_above_s = (rd_adr >= BASE_ADR);
    ram_wr_s   = ce_wr_dat && (com == COM_RAM) && wr_above_s && (wr_off_s < WIN_SIZE);
    reg_wr_s   = ce_wr_dat && (com == COM_REG_WR) && wr_above_s;
    crc_clr_s  = ce_wr_dat && (com == COM_CRC_CLR);
  end

  // Read data select; unmapped or inactive reads yield zero with no valid.
  always_comb begin
    rd_hit_s  = 1'b0;
    rd_data_s = '0;
    if ((com == COM_REG_RD) && rd_above_s && (rd_off_s < SW_OFF)) begin
      rd_hit_s  = 1'b1;
      rd_data_s = reg_q[int'(rd_off_s)*DW +: DW];
    end else if ((com == COM_REG_RD) && rd_above_s && (rd_off_s == SW_OFF)) begin
      rd_hit_s  = 1'b1;
      rd_data_s = sw;
    end else if ((com == COM_REG_RD) && rd_above_s && (rd_off_s == CRC_OFF)) begin
      rd_hit_s  = 1'b1;
      rd_data_s = DW'(crc_q);
    end else if ((com == COM_RAM) && rd_above_s && (rd_off_s < WIN_SIZE)) begin
      rd_hit_s  = 1'b1;
      rd_data_s = mem_r[rd_adr[MEM_AW-1:0]];
    end else begin
      rd_hit_s  = 1'b0;
      rd_data_s = '0;
    end
  end

  // RAM storage, not reset; the write lands after the same-cycle read is sampled.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      mem_r[wr_adr[MEM_AW-1:0]] <= rx_dat;
    end
  end

  // Output registers, CRC engine and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q  <= '0;
      crc_q  <= 8'h00;
      my_dat <= '0;
      rd_vld <= 1'b0;
    end else begin
      for (int k = 0; k < N_REG; k++) begin
        if (reg_wr_s && (wr_off_s == 16'(k))) begin
          reg_q[k*DW +: DW] <= rx_dat;
        end
      end
      if (crc_clr_s) begin
        crc_q <= 8'h00;
      end else if (ram_wr_s) begin
        crc_q <= crc8_byte(crc_q, 8'(rx_dat));
      end
      my_dat <= rd_data_s;
      rd_vld <= rd_hit_s;
    end
  end

endmodule
